// File: rtl/regfile_ctrl_pkg.sv
// Shared types and encodings for the register-file controller.
package rm_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_IMM = 3'd5,
        S_WR_REG = 3'd6
    } ctrl_state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Instruction handshake plus register-file / datapath control bundle.
interface regfile_ctrl_if #(parameter int DATA_W = 16);
    logic              s;
    logic [DATA_W-1:0] in;
    logic              w;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [1:0]        vsel;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic [DATA_W-1:0] sximm8;
    logic [DATA_W-1:0] sximm5;

    modport master (
        output s, in,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8, sximm5
    );

    modport slave (
        input  s, in,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8, sximm5
    );
endinterface

// File: rtl/regfile_ctrl_instr_dec.sv
// Combinational IR field extraction and immediate sign extension.
module instr_dec #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ir_i,
    output logic [2:0]        opcode_o,
    output logic [1:0]        op_o,
    output logic [2:0]        rn_o,
    output logic [2:0]        rd_o,
    output logic [1:0]        sh_o,
    output logic [2:0]        rm_o,
    output logic [DATA_W-1:0] sximm8_o,
    output logic [DATA_W-1:0] sximm5_o
);
    assign opcode_o = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{(DATA_W-8){ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{(DATA_W-5){ir_i[4]}}, ir_i[4:0]};
endmodule

// File: rtl/regfile_ctrl.sv
// Multicycle Moore controller sequencing one instruction through the register file.
module regfile_ctrl
    import rm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    regfile_ctrl_if.slave bus
);
    ctrl_state_t       state_q, state_d;
    logic [DATA_W-1:0] ir_q;

    logic [2:0]        opcode, rn, rd, rm;
    logic [1:0]        op, sh;
    logic [DATA_W-1:0] sximm8, sximm5;

    instr_dec #(.DATA_W(DATA_W)) u_dec (
        .ir_i     (ir_q),
        .opcode_o (opcode),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .sh_o     (sh),
        .rm_o     (rm),
        .sximm8_o (sximm8),
        .sximm5_o (sximm5)
    );

    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == ALU_CMP);
    assign is_mvn     = is_alu && (op == ALU_MVN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && bus.s)
                ir_q <= bus.in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (bus.s) state_d = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                state_d = S_WR_IMM;
                else if (is_mov_reg || is_mvn) state_d = S_GET_B;
                else if (is_alu)               state_d = S_GET_A;
                else                           state_d = S_WAIT;
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_IMM: state_d = S_WAIT;
            S_WR_REG: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w        = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.vsel     = VSEL_C;
        case (state_q)
            S_WAIT:   bus.w = 1'b1;
            S_GET_A:  begin bus.readnum = rn; bus.loada = 1'b1; end
            S_GET_B:  begin bus.readnum = rm; bus.loadb = 1'b1; end
            S_EXEC:   begin
                // MOV reg and MVN are single-operand: A is forced to zero
                bus.asel  = is_mov_reg || is_mvn;
                bus.loadc = !is_cmp;
                bus.loads = is_cmp;
            end
            S_WR_IMM: begin bus.writenum = rn; bus.vsel = VSEL_IMM8; bus.write = 1'b1; end
            S_WR_REG: begin bus.writenum = rd; bus.vsel = VSEL_C;    bus.write = 1'b1; end
            default:  ;
        endcase
    end

    assign bus.shift  = sh;
    assign bus.ALUop  = op;
    assign bus.sximm8 = sximm8;
    assign bus.sximm5 = sximm5;
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed-vector bench for regfile_ctrl.
module tb_regfile_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;

    regfile_ctrl_if #(.DATA_W(16)) bus ();

    regfile_ctrl #(.DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.write) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel}
    function automatic logic [15:0] ctl();
        return {bus.w, bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb,
                bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel};
    endfunction

    function automatic logic [15:0] exp_ctl(input logic w, input logic [2:0] rn, input logic [2:0] wn,
                                            input logic wr, input logic la, input logic lb,
                                            input logic lc, input logic ls, input logic as,
                                            input logic [1:0] vs);
        return {w, rn, wn, wr, la, lb, lc, ls, as, 1'b0, vs};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse s for one edge with instruction ir; returns positioned in DECODE.
    task automatic start(input logic [15:0] ir);
        bus.in = ir;
        bus.s  = 1'b1;
        step();
        bus.s  = 1'b0;
        bus.in = 16'h5555;
    endtask

    localparam logic [15:0] IDLE = 16'h8000;

    initial begin
        int wr0;
        reset  = 1'b1;
        bus.s  = 1'b0;
        bus.in = 16'h0000;
        step();
        reset = 1'b0;
        chk("rst_ctl", ctl(), IDLE);
        chk("rst_imm", {bus.shift, bus.ALUop, bus.sximm8}, 32'h0);
        step();
        chk("idle_ctl", ctl(), IDLE);

        // MOV R2,#-2
        wr0 = wr_cnt;
        start(16'hD2FE);
        chk("movi_dec", ctl(), 16'h0000);
        chk("movi_imm8", bus.sximm8, 32'h0000FFFE);
        chk("movi_imm5", bus.sximm5, 32'h0000FFFE);
        step();
        chk("movi_wr", ctl(), exp_ctl(0, 0, 2, 1, 0, 0, 0, 0, 0, 2'b10));
        step();
        chk("movi_done", ctl(), IDLE);
        chk("movi_wcnt", wr_cnt - wr0, 1);

        // ADD R5,R1,R2
        wr0 = wr_cnt;
        start(16'hA1A2);
        chk("add_dec", ctl(), 16'h0000);
        chk("add_op", {bus.shift, bus.ALUop}, 4'b0000);
        step(); chk("add_geta", ctl(), exp_ctl(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        step(); chk("add_getb", ctl(), exp_ctl(0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00));
        step(); chk("add_exec", ctl(), exp_ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
        step(); chk("add_wr",   ctl(), exp_ctl(0, 0, 5, 1, 0, 0, 0, 0, 0, 2'b00));
        step(); chk("add_done", ctl(), IDLE);
        chk("add_wcnt", wr_cnt - wr0, 1);

        // CMP R1,R2
        wr0 = wr_cnt;
        start(16'hA902);
        chk("cmp_op", bus.ALUop, 2'b01);
        step(); chk("cmp_geta", ctl(), exp_ctl(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        step(); chk("cmp_getb", ctl(), exp_ctl(0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00));
        step(); chk("cmp_exec", ctl(), exp_ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00));
        step(); chk("cmp_done", ctl(), IDLE);
        chk("cmp_wcnt", wr_cnt - wr0, 0);

        // MOV R3, R4 LSL-ish (sh=01)
        wr0 = wr_cnt;
        start(16'hC06C);
        chk("movr_sh", {bus.shift, bus.ALUop}, 4'b0100);
        step(); chk("movr_getb", ctl(), exp_ctl(0, 4, 0, 0, 0, 1, 0, 0, 0, 2'b00));
        step(); chk("movr_exec", ctl(), exp_ctl(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00));
        step(); chk("movr_wr",   ctl(), exp_ctl(0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00));
        step(); chk("movr_done", ctl(), IDLE);
        chk("movr_wcnt", wr_cnt - wr0, 1);

        // MVN R6, R7
        start(16'hB8C7);
        chk("mvn_op", bus.ALUop, 2'b11);
        step(); chk("mvn_getb", ctl(), exp_ctl(0, 7, 0, 0, 0, 1, 0, 0, 0, 2'b00));
        step(); chk("mvn_exec", ctl(), exp_ctl(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00));
        step(); chk("mvn_wr",   ctl(), exp_ctl(0, 0, 6, 1, 0, 0, 0, 0, 0, 2'b00));
        step(); chk("mvn_done", ctl(), IDLE);

        // Illegal opcode: DECODE then straight back to WAIT
        wr0 = wr_cnt;
        start(16'hE000);
        chk("ill_dec", ctl(), 16'h0000);
        step(); chk("ill_done", ctl(), IDLE);
        chk("ill_wcnt", wr_cnt - wr0, 0);

        // Reset during GET_B of ADD, then a clean MOV imm
        wr0 = wr_cnt;
        start(16'hA1A2);
        step();
        bus.s = 1'b1;  // ignored outside WAIT
        step(); chk("rmid_getb", ctl(), exp_ctl(0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00));
        bus.s = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_ctl", ctl(), IDLE);
        chk("rmid_ir", bus.sximm8, 32'h0);
        step(); chk("rmid_hold", ctl(), IDLE);
        chk("rmid_wcnt", wr_cnt - wr0, 0);
        start(16'hD47F);
        step(); chk("rmid_movi", ctl(), exp_ctl(0, 0, 4, 1, 0, 0, 0, 0, 0, 2'b10));
        chk("rmid_imm8", bus.sximm8, 32'h0000007F);
        step(); chk("rmid_done", ctl(), IDLE);

        // s held high: back-to-back MOV imm
        bus.in = 16'hD1FF;
        bus.s  = 1'b1;
        step(); chk("b2b_dec1", ctl(), 16'h0000);
        bus.in = 16'hD303;
        step(); chk("b2b_wr1", ctl(), exp_ctl(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b10));
        chk("b2b_imm1", bus.sximm8, 32'h0000FFFF);
        step(); chk("b2b_wait", ctl(), IDLE);
        step(); chk("b2b_dec2", ctl(), 16'h0000);
        bus.s = 1'b0;
        step(); chk("b2b_wr2", ctl(), exp_ctl(0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b10));
        chk("b2b_imm2", bus.sximm8, 32'h00000003);
        step(); chk("b2b_done", ctl(), IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
